phrase_sequencer: RTL
=====================

Name: phrase_sequencer

Overview:
- Walks a song arrangement table (phrase-ID ROM) one step at a time and presents the current phrase ID to the note/waveform generators.
- Generalised successor to the fixed arrangement lookup: parametrised table geometry, steps per phrase, loop point, play/pause/halt control, and a loop or one-shot end-of-song mode.
- Sits between the tempo tick generator and the per-phrase pattern ROMs. The arrangement ROM stays external and combinational, and is reached through rom_addr/rom_data.

Parameters:
- ADDR_W, 8, arrangement ROM address width.
- ID_W, 5, phrase ID width (ROM entry width).
- SONG_LEN, 153, number of valid ROM entries; last entry index is SONG_LEN-1. Legal range 2..2^ADDR_W.
- START_ADDR, 1, first address played after start. Legal range 0..SONG_LEN-1.
- LOOP_ADDR, 1, address re-entered on wrap when looping. Legal range START_ADDR..SONG_LEN-1.
- STEPS_PER_PHRASE, 16, step ticks per ROM entry. Legal range ≥1. STEP_W = max(1, clog2(STEPS_PER_PHRASE)).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begin playback from START_ADDR.
- halt  in  1  one-cycle pulse; stop playback and return to IDLE.
- pause  in  1  level; while high, step_tick is ignored and all state is held.
- loop_en  in  1  level, sampled at the end of the song; 1 = wrap to LOOP_ADDR, 0 = stop in DONE.
- step_tick  in  1  one-cycle tempo strobe.
- rom_addr  out  ADDR_W  registered address to the arrangement ROM.
- rom_data  in  ID_W  combinational ROM entry for rom_addr.
- phrase_id  out  ID_W  registered current phrase ID; 0 = silence.
- step_idx  out  STEP_W  step position within the current phrase.
- phrase_start  out  1  one-cycle pulse when phrase_id takes a new entry.
- song_end  out  1  one-cycle pulse when the last step of the last entry completes.
- busy  out  1  high in PLAY (including while paused).

Behaviour:
- Reset (async, rst_n=0): state=IDLE, rom_addr=0, phrase_id=0, step_idx=0, phrase_start=0, song_end=0, busy=0. Deassertion takes effect on the next clk edge.
- States: IDLE, PLAY, DONE.
- Command priority within a cycle: halt > start > step_tick.
- IDLE:
  - Outputs: phrase_id=0, step_idx=0, busy=0.
  - On start: rom_addr<=START_ADDR, step_idx<=0, go to PLAY, set internal load flag.
- PLAY:
  - busy=1.
  - On the cycle after any rom_addr change (load flag set): phrase_id<=rom_data and phrase_start=1. Address-to-phrase_id latency is exactly 1 clk.
  - On step_tick with pause=0 and step_idx<STEPS_PER_PHRASE-1: step_idx++.
  - On step_tick with pause=0 and step_idx==STEPS_PER_PHRASE-1: step_idx<=0, then:
    - rom_addr<SONG_LEN-1: rom_addr++, set load flag.
    - rom_addr==SONG_LEN-1 and loop_en=1: rom_addr<=LOOP_ADDR, set load flag, song_end=1, stay in PLAY.
    - rom_addr==SONG_LEN-1 and loop_en=0: song_end=1, phrase_id<=0, go to DONE, rom_addr held.
  - STEPS_PER_PHRASE=1: every accepted tick advances the address.
  - start in PLAY: restart. rom_addr<=START_ADDR, step_idx<=0, load flag set.
- DONE:
  - busy=0, phrase_id=0.
  - start: same as from IDLE.
  - halt: go to IDLE, rom_addr<=0.
- halt in any state: IDLE with the reset output values on the next clk edge. This also clears the load flag and any pending pulses.
- pause=1: step_tick is dropped, not queued. The load and phrase_start update still completes, because it is not tick driven.
- A step_tick in the same cycle as a load is accepted normally.
- rom_addr never exceeds SONG_LEN-1. Address arithmetic is ADDR_W bits wide with no overflow path.
- phrase_start and song_end are each exactly one cycle wide. When a looping wrap occurs, song_end and the load are raised in the same cycle, and phrase_start follows one cycle later.

Decomposition:
- Shared package phrase_seq_pkg holds:
  - the state enum (IDLE, PLAY, DONE);
  - default widths ADDR_W/ID_W;
  - PHRASE_SILENCE = 0.
- One sub-module, phrase_step_counter: a modulo-STEPS_PER_PHRASE counter with clear, enable, and a wrap output. The FSM and address logic stay in phrase_sequencer.
- The ROM is instantiated by the parent, not inside this block.

Test Plan:
- Reset, then start, with SONG_LEN=4, START_ADDR=1, LOOP_ADDR=2, STEPS=2, ROM {0,5,6,7}: rom_addr=1 one cycle after start; one cycle later phrase_id=5 and phrase_start=1. After 2 ticks, rom_addr=2, then phrase_id=6.
- Same configuration, loop_en=1, run to the end: the 2nd tick at addr 3 gives song_end=1 and rom_addr=2, followed by phrase_id=6 and phrase_start. busy stays 1.
- loop_en=0, run to the end: song_end=1 for 1 cycle, state DONE, phrase_id=0, busy=0, rom_addr=3. Then start gives rom_addr=1 and phrase_id=5.
- pause=1 during PLAY with 5 ticks: step_idx, rom_addr and phrase_id unchanged. Release pause, 1 tick: step_idx advances by exactly 1.
- Simultaneous events: start+halt in the same cycle gives IDLE. A tick together with halt gives IDLE, all outputs 0.
- rst_n dropped mid-phrase (addr 2, step 1): all outputs 0 immediately, with no clk edge needed. After release, the block stays in IDLE until start.

Source files
------------

// File: rtl/phrase_seq_pkg.sv
// Shared types and defaults for the song arrangement sequencer.
package phrase_seq_pkg;

   localparam int unsigned DEF_ADDR_W     = 8;
   localparam int unsigned DEF_ID_W       = 5;
   localparam int unsigned PHRASE_SILENCE = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_DONE = 2'd2
   } seq_state_e;

endpackage

// File: rtl/phrase_seq_step_counter.sv
// Modulo-STEPS step position counter within one phrase; clear beats enable.
module phrase_step_counter #(
   parameter int unsigned STEPS  = 16,
   parameter int unsigned STEP_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_i,
   input  logic              en_i,
   output logic [STEP_W-1:0] cnt_o,
   output logic              last_c_o
);

   localparam logic [STEP_W-1:0] LAST = STEP_W'(STEPS - 1);

   logic [STEP_W-1:0] cnt_q;
   logic [STEP_W-1:0] cnt_d;

   assign last_c_o = (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = last_c_o ? '0 : cnt_q + STEP_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/phrase_sequencer.sv
// Walks the external arrangement ROM one phrase per STEPS_PER_PHRASE ticks and
// presents the current phrase ID, with play/pause/halt and loop or one-shot end.
module phrase_sequencer
   import phrase_seq_pkg::*;
#(
   parameter  int unsigned ADDR_W           = DEF_ADDR_W,
   parameter  int unsigned ID_W             = DEF_ID_W,
   parameter  int unsigned SONG_LEN         = 153,
   parameter  int unsigned START_ADDR       = 1,
   parameter  int unsigned LOOP_ADDR        = 1,
   parameter  int unsigned STEPS_PER_PHRASE = 16,
   localparam int unsigned STEP_W           = (STEPS_PER_PHRASE > 1) ? $clog2(STEPS_PER_PHRASE) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              halt,
   input  logic              pause,
   input  logic              loop_en,
   input  logic              step_tick,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [ID_W-1:0]   rom_data,
   output logic [ID_W-1:0]   phrase_id,
   output logic [STEP_W-1:0] step_idx,
   output logic              phrase_start,
   output logic              song_end,
   output logic              busy
);

   localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(SONG_LEN - 1);
   localparam logic [ADDR_W-1:0] START_A = ADDR_W'(START_ADDR);
   localparam logic [ADDR_W-1:0] LOOP_A  = ADDR_W'(LOOP_ADDR);
   localparam logic [ID_W-1:0]   SILENCE = ID_W'(PHRASE_SILENCE);

   seq_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ID_W-1:0]   phrase_q, phrase_d;
   logic              load_q, load_d;
   logic              pstart_q, pstart_d;
   logic              send_q, send_d;
   logic              busy_q, busy_d;

   logic              cnt_clr_c;
   logic              cnt_en_c;
   logic              cnt_last_c;

   // A tick is accepted only in PLAY, unpaused, and when no command outranks it.
   assign cnt_en_c = (state_q == ST_PLAY) && step_tick && !pause && !halt && !start;

   phrase_step_counter #(
      .STEPS  (STEPS_PER_PHRASE),
      .STEP_W (STEP_W)
   ) u_step_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_i    (cnt_clr_c),
      .en_i     (cnt_en_c),
      .cnt_o    (step_idx),
      .last_c_o (cnt_last_c)
   );

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      phrase_d  = phrase_q;
      load_d    = 1'b0;
      pstart_d  = 1'b0;
      send_d    = 1'b0;
      cnt_clr_c = 1'b0;

      // Pending load completes regardless of ticks or pause; only halt cancels it.
      if ((state_q == ST_PLAY) && load_q) begin
         phrase_d = rom_data;
         pstart_d = 1'b1;
      end

      if (halt) begin
         state_d   = ST_IDLE;
         addr_d    = '0;
         phrase_d  = SILENCE;
         pstart_d  = 1'b0;
         cnt_clr_c = 1'b1;
      end else if (start) begin
         state_d   = ST_PLAY;
         addr_d    = START_A;
         load_d    = 1'b1;
         cnt_clr_c = 1'b1;
      end else begin
         unique case (state_q)
            ST_PLAY: begin
               if (cnt_en_c && cnt_last_c) begin
                  if (addr_q < LAST_A) begin
                     addr_d = addr_q + ADDR_W'(1);
                     load_d = 1'b1;
                  end else begin
                     send_d = 1'b1;
                     if (loop_en) begin
                        addr_d = LOOP_A;
                        load_d = 1'b1;
                     end else begin
                        state_d  = ST_DONE;
                        phrase_d = SILENCE;
                        pstart_d = 1'b0;
                     end
                  end
               end
            end
            default: ;
         endcase
      end

      busy_d = (state_d == ST_PLAY);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         phrase_q <= SILENCE;
         load_q   <= 1'b0;
         pstart_q <= 1'b0;
         send_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         phrase_q <= phrase_d;
         load_q   <= load_d;
         pstart_q <= pstart_d;
         send_q   <= send_d;
         busy_q   <= busy_d;
      end
   end

   assign rom_addr     = addr_q;
   assign phrase_id    = phrase_q;
   assign phrase_start = pstart_q;
   assign song_end     = send_q;
   assign busy         = busy_q;

endmodule
